// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/half/word access, wait states and fault reporting.
// Optional DMEM_CLEAR_EN: zero-sweep of the array after reset release.
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
`ifdef DMEM_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd3;
  logic [AW-1:0] clr_q, clr_d;
`endif

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d, signed_q, signed_d, fault_q, fault_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  // Commit-time view: straight from the inputs when there are no wait states.
  logic          commit, c_write, c_signed, c_fault, mem_we;
  logic [1:0]    c_size, c_lane;
  logic [31:0]   c_addr, c_wdata, rd_word, rd_sh, ld_val, w_data;
  logic [AW-1:0] c_idx;
  logic [3:0]    w_be;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

  always_comb begin
    commit   = ((state_q == S_WAIT) && (cnt_q == 3'd1)) ||
               ((state_q == S_IDLE) && req_valid && (WAIT_STATES == 0));
    c_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
    c_size   = (state_q == S_IDLE) ? req_size   : size_q;
    c_write  = (state_q == S_IDLE) ? req_write  : write_q;
    c_signed = (state_q == S_IDLE) ? req_signed : signed_q;
    c_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    c_lane   = c_addr[1:0];
    c_idx    = c_addr[AW+1:2];
    c_fault  = (c_size == 2'b11) || ((c_size == 2'b01) && c_addr[0]) ||
               ((c_size == 2'b10) && (c_addr[1:0] != 2'b00)) ||
               (c_addr[31:2] >= 30'(DEPTH_WORDS));
    rd_word  = mem_q[c_idx];
    rd_sh    = rd_word >> {c_lane, 3'b000};
    case (c_size)
      2'b00:   ld_val = {{24{c_signed & rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   ld_val = {{16{c_signed & rd_sh[15]}}, rd_sh[15:0]};
      default: ld_val = rd_word;
    endcase
    case (c_size)
      2'b00:   begin w_be = 4'b0001 << c_lane;                 w_data = {4{c_wdata[7:0]}};  end
      2'b01:   begin w_be = c_lane[1] ? 4'b1100 : 4'b0011;     w_data = {2{c_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                           w_data = c_wdata;            end
    endcase
    mem_we   = commit && c_write && !c_fault;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
`ifdef DMEM_CLEAR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d   = req_addr;
        size_d   = req_size;
        write_d  = req_write;
        signed_d = req_signed;
        wdata_d  = req_wdata;
        cnt_d    = WS;
        state_d  = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_RESP;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
`ifdef DMEM_CLEAR_EN
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH_WORDS - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rdata_d = (c_write || c_fault) ? 32'h0 : ld_val;
      fault_d = c_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_CLEAR_EN
      state_q <= S_CLEAR;
      clr_q   <= '0;
`else
      state_q <= S_IDLE;
`endif
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
`ifdef DMEM_CLEAR_EN
      clr_q    <= clr_d;
`endif
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // Array is never reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) mem_q[c_idx][8*b +: 8] <= w_data[8*b +: 8];
`ifdef DMEM_CLEAR_EN
    if (state_q == S_CLEAR) mem_q[clr_q] <= '0;
`endif
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised bench for data_memory_ctrl against a byte-level reference memory model.
module tb_data_memory_ctrl;
  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  int n_chk = 0, n_fail = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: fault rules, byte lanes and sign extension from plain arithmetic.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] er, output logic ef);
    int unsigned idx, sh;
    logic [31:0] mask, v;
    ef = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0) ||
         ((a / 4) >= DEPTH);
    er = 32'h0;
    if (ef) return;
    idx = a / 4;
    sh  = (a % 4) * 8;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (wr) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
    end else begin
      v = (ref_mem[idx] >> sh) & mask;
      if (sg && sz == 2'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
      if (sg && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      er = v;
    end
  endfunction

  task automatic wait_clear();
`ifdef DMEM_CLEAR_EN
    int n = 0;
    while (!req_ready && n < 4 * DEPTH) begin
      @(posedge clk); #1; n++;
    end
    chk("clear_cycles", 32'(n), DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`endif
  endtask

  task automatic xfer(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input int hold, input bit junk);
    logic [31:0] er, r0;
    logic ef, f0;
    int n;
    model(wr, sz, sg, a, wd, er, ef);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    if (junk) begin
      req_write = 1'b1; req_size = 2'd2;
      req_addr = 4 * $urandom_range(0, DEPTH - 1); req_wdata = $urandom;
    end else req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!rsp_valid && n <= WS) chk("req_ready_wait", 32'(req_ready), 0);
    end while (!rsp_valid && n < 20);
    chk("latency", 32'(n), WS + 1);
    if (!rsp_valid) begin
      req_valid = 1'b0; rsp_ready = 1'b1;
      return;
    end
    chk("rdata", rsp_rdata, er);
    chk("fault", 32'(rsp_fault), 32'(ef));
    r0 = rsp_rdata; f0 = rsp_fault;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, r0);
      chk("hold_fault", 32'(rsp_fault), 32'(f0));
      chk("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_done", 32'(rsp_valid), 0);
    chk("idle_again", 32'(req_ready), 1);
  endtask

  initial begin
    logic [31:0] a;
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_fault", 32'(rsp_fault), 0);
`ifndef DMEM_CLEAR_EN
    chk("rst_ready", 32'(req_ready), 1);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 wait_clear();
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) xfer(0, 2'd2, 0, 32'(4 * i), 0, 0, 0);
`endif
    // Fill the array so every later load has a known expected value.
    for (int i = 0; i < DEPTH; i++) xfer(1, 2'd2, 0, 32'(4 * i), $urandom, 0, 0);

    xfer(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 0);
    xfer(0, 2'd2, 0, 32'h10, 0, 0, 0);
    xfer(1, 2'd0, 0, 32'h12, 32'h0000_0055, 0, 0);
    xfer(0, 2'd2, 0, 32'h10, 0, 0, 0);
    xfer(0, 2'd0, 1, 32'h13, 0, 0, 0);
    xfer(0, 2'd1, 0, 32'h10, 0, 0, 0);
    xfer(0, 2'd1, 0, 32'h11, 0, 0, 0);
    xfer(1, 2'd2, 0, 32'h0E, 32'h1234_5678, 0, 0);
    xfer(0, 2'd2, 0, 32'h100, 0, 0, 0);
    xfer(1, 2'd3, 0, 32'h0C, 32'hCAFE_F00D, 0, 0);
    xfer(0, 2'd2, 0, 32'h0C, 0, 0, 0);
    xfer(1, 2'd1, 0, 32'h0E, 32'hAAAA_8001, 5, 1);
    xfer(0, 2'd1, 1, 32'h0E, 0, 5, 0);

    // Reset during WAIT of a store: nothing committed.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    #1 wait_clear();
    xfer(0, 2'd2, 0, 32'h20, 0, 0, 0);

    // Reset while holding a response drops rsp_valid at once.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h20; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (WS + 1) @(negedge clk);
    chk("resp_before_rst", 32'(rsp_valid), 1);
    rst_n = 1'b0; #1;
    chk("rst_resp_valid", 32'(rsp_valid), 0);
    chk("rst_resp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    #1 wait_clear();

    for (int k = 0; k < 250; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 31));
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH; i++) xfer(0, 2'd2, 0, 32'(4 * i), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
